// File: rtl/cpu_pkg.sv
// Shared CPU definitions: data-memory controller state encoding and access timeout.
package cpu_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_FINISH = 2'd2
  } dmem_state_t;

  localparam int DMEM_TIMEOUT = 15;

endpackage

// File: rtl/dmem_controller.sv
// Data-memory controller: turns CPU load/store requests into registered memory
// strobes, stalls the CPU while the memory is busy, and aborts hung accesses.
module dmem_controller
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = DMEM_TIMEOUT
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       READ,
  input  logic       WRITE,
  input  logic [7:0] ADDRESS,
  input  logic [7:0] WRITEDATA,
  output logic [7:0] READDATA,
  output logic       BUSYWAIT,
  output logic       MEM_READ,
  output logic       MEM_WRITE,
  output logic [7:0] MEM_ADDRESS,
  output logic [7:0] MEM_WRITEDATA,
  input  logic [7:0] MEM_READDATA,
  input  logic       MEM_BUSYWAIT,
  output logic       ERROR,
  output logic [1:0] DEBUG_STATE
);

  // Handshake: the CPU holds READ or WRITE as a level until BUSYWAIT falls; the
  // single low-BUSYWAIT FINISH cycle is the completion beat, and READDATA is valid
  // from that cycle on. Requests seen during FINISH are ignored.

  dmem_state_t state, next_state;
  logic [3:0]  cnt;
  logic        req_one;
  logic        req_both;
  logic        mem_done;
  logic        cnt_last;

  assign req_one  = READ ^ WRITE;
  assign req_both = READ & WRITE;
  // The first ACCESS cycle ignores MEM_BUSYWAIT: the memory has not yet seen the strobe.
  assign mem_done = (cnt != 4'd0) && !MEM_BUSYWAIT;
  assign cnt_last = (int'(cnt) + 1) >= TIMEOUT;

  always_ff @(posedge CLK) begin
    if (!RESET) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (req_one) next_state = S_ACCESS;
      S_ACCESS: if (mem_done || cnt_last) next_state = S_FINISH;
      S_FINISH: next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  always_comb begin
    BUSYWAIT    = 1'b0;
    DEBUG_STATE = state;
    case (state)
      S_IDLE:   BUSYWAIT = RESET & req_one;
      S_ACCESS: BUSYWAIT = RESET;
      default:  BUSYWAIT = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      MEM_READ      <= 1'b0;
      MEM_WRITE     <= 1'b0;
      MEM_ADDRESS   <= 8'h00;
      MEM_WRITEDATA <= 8'h00;
      READDATA      <= 8'h00;
      ERROR         <= 1'b0;
      cnt           <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_one) begin
            MEM_ADDRESS   <= ADDRESS;
            MEM_WRITEDATA <= WRITEDATA;
            MEM_READ      <= READ;
            MEM_WRITE     <= WRITE;
            cnt           <= 4'd0;
          end else if (req_both) begin
            ERROR <= 1'b1;
          end
        end
        S_ACCESS: begin
          // Completion is tested first so a late reply on the last cycle still succeeds.
          if (mem_done) begin
            if (MEM_READ) READDATA <= MEM_READDATA;
            MEM_READ  <= 1'b0;
            MEM_WRITE <= 1'b0;
          end else if (cnt_last) begin
            ERROR <= 1'b1;
            if (MEM_READ) READDATA <= 8'h00;
            MEM_READ  <= 1'b0;
            MEM_WRITE <= 1'b0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_controller.sv
// Bench for dmem_controller: behavioural memory with programmable latency, and a
// scoreboard that checks every completed access against hand-computed results.
module tb_dmem_controller;
  import cpu_pkg::*;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       READ = 1'b0;
  logic       WRITE = 1'b0;
  logic [7:0] ADDRESS = 8'h00;
  logic [7:0] WRITEDATA = 8'h00;
  logic [7:0] READDATA;
  logic       BUSYWAIT;
  logic       MEM_READ;
  logic       MEM_WRITE;
  logic [7:0] MEM_ADDRESS;
  logic [7:0] MEM_WRITEDATA;
  logic [7:0] MEM_READDATA;
  logic       MEM_BUSYWAIT;
  logic       ERROR;
  logic [1:0] DEBUG_STATE;

  dmem_controller #(.TIMEOUT(15)) dut (
    .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE),
    .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA), .READDATA(READDATA),
    .BUSYWAIT(BUSYWAIT), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
    .MEM_ADDRESS(MEM_ADDRESS), .MEM_WRITEDATA(MEM_WRITEDATA),
    .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT),
    .ERROR(ERROR), .DEBUG_STATE(DEBUG_STATE)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  // ---------------- memory model ----------------
  int         mem_lat = 0;
  logic [7:0] mem_cnt = 8'd0;
  logic [7:0] mem [256];
  logic       mem_vld [256];

  function automatic logic [7:0] mem_init(input logic [7:0] a);
    return (a == 8'h10) ? 8'hA5 : (a ^ 8'h5A);
  endfunction

  // Busy for mem_lat cycles after the strobe rises, then ready.
  assign MEM_BUSYWAIT = (MEM_READ | MEM_WRITE) && (int'(mem_cnt) < mem_lat);
  assign MEM_READDATA = (mem_vld[MEM_ADDRESS] === 1'b1) ? mem[MEM_ADDRESS] : mem_init(MEM_ADDRESS);

  always @(posedge CLK) begin
    if (MEM_READ | MEM_WRITE) mem_cnt <= mem_cnt + 8'd1;
    else                      mem_cnt <= 8'd0;
    if (MEM_WRITE && !MEM_BUSYWAIT) begin
      mem[MEM_ADDRESS]     <= MEM_WRITEDATA;
      mem_vld[MEM_ADDRESS] <= 1'b1;
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail = 0;
  // {readdata[24:17], error[16], busy_cycles[15:8], strobe_cycles[7:0]}
  logic [24:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a completion is the first low-BUSYWAIT cycle after a stall.
  int          busy_cnt = 0;
  int          strb_cnt = 0;
  logic [24:0] mon_e;

  always @(negedge CLK) begin
    if (!RESET) begin
      busy_cnt = 0;
      strb_cnt = 0;
    end else begin
      if (MEM_READ | MEM_WRITE) strb_cnt++;
      if (BUSYWAIT) begin
        busy_cnt++;
      end else if (busy_cnt > 0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_completion", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("txn_readdata", 32'(READDATA), 32'(mon_e[24:17]));
          check("txn_error", 32'(ERROR), 32'(mon_e[16]));
          check("txn_busy_cycles", 32'(busy_cnt), 32'(mon_e[15:8]));
          check("txn_strobe_cycles", 32'(strb_cnt), 32'(mon_e[7:0]));
        end
        busy_cnt = 0;
        strb_cnt = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic expect_txn(input logic [7:0] rd, input logic er, input int busy, input int strb);
    exp_q.push_back({rd, er, 8'(busy), 8'(strb)});
  endtask

  task automatic start_req(input logic r, input logic w, input logic [7:0] a,
                           input logic [7:0] d, input int lat);
    @(posedge CLK);
    #1;
    mem_lat   = lat;
    ADDRESS   = a;
    WRITEDATA = d;
    READ      = r;
    WRITE     = w;
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (BUSYWAIT && k < 64);
    check({name, "_done"}, 32'(BUSYWAIT), 32'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_mem_read"}, 32'(MEM_READ), 32'd0);
    check({name, "_mem_write"}, 32'(MEM_WRITE), 32'd0);
    check({name, "_mem_addr"}, 32'(MEM_ADDRESS), 32'd0);
    check({name, "_mem_wdata"}, 32'(MEM_WRITEDATA), 32'd0);
    check({name, "_readdata"}, 32'(READDATA), 32'd0);
    check({name, "_error"}, 32'(ERROR), 32'd0);
    check({name, "_busywait"}, 32'(BUSYWAIT), 32'd0);
    check({name, "_state"}, 32'(DEBUG_STATE), 32'(S_IDLE));
  endtask

  task automatic pulse_reset();
    @(posedge CLK);
    #1 RESET = 1'b0;
    @(posedge CLK);
    #1 RESET = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_reset_outputs("por");
    #1 RESET = 1'b1;

    // Load with 4 busy cycles.
    expect_txn(8'hA5, 1'b0, 6, 5);
    start_req(1'b1, 1'b0, 8'h10, 8'h00, 4);
    wait_done("load_lat4");
    READ = 1'b0;
    @(negedge CLK);
    check("idle_after_finish_busy", 32'(BUSYWAIT), 32'd0);

    // Store with an immediately ready memory; READDATA keeps the previous load.
    expect_txn(8'hA5, 1'b0, 3, 2);
    start_req(1'b0, 1'b1, 8'h20, 8'h3C, 0);
    wait_done("store_lat0");
    WRITE = 1'b0;
    @(negedge CLK);
    check("store_mem_0x20", 32'(mem[8'h20]), 32'h3C);

    // Memory answers on the last allowed ACCESS cycle: completion, no error.
    expect_txn(8'h3C, 1'b0, 16, 15);
    start_req(1'b1, 1'b0, 8'h20, 8'h00, 14);
    wait_done("load_lat14");
    READ = 1'b0;

    // Back-to-back loads with READ held through FINISH.
    expect_txn(8'hA5, 1'b0, 3, 2);
    expect_txn(8'h3C, 1'b0, 3, 2);
    start_req(1'b1, 1'b0, 8'h10, 8'h00, 0);
    wait_done("b2b_first");
    ADDRESS = 8'h20;
    check("b2b_finish_state", 32'(DEBUG_STATE), 32'(S_FINISH));
    @(negedge CLK);
    check("b2b_idle_state", 32'(DEBUG_STATE), 32'(S_IDLE));
    check("b2b_idle_busy", 32'(BUSYWAIT), 32'd1);
    check("b2b_idle_no_strobe", 32'(MEM_READ), 32'd0);
    wait_done("b2b_second");
    READ = 1'b0;

    // Memory stuck busy: abort after 15 ACCESS cycles.
    expect_txn(8'h00, 1'b1, 16, 15);
    start_req(1'b1, 1'b0, 8'h10, 8'h00, 255);
    wait_done("timeout");
    READ = 1'b0;
    check("timeout_finish_state", 32'(DEBUG_STATE), 32'(S_FINISH));
    @(negedge CLK);
    check("timeout_then_idle", 32'(DEBUG_STATE), 32'(S_IDLE));

    // ERROR stays set across a later good access.
    expect_txn(8'hA5, 1'b1, 3, 2);
    start_req(1'b1, 1'b0, 8'h10, 8'h00, 0);
    wait_done("sticky_load");
    READ = 1'b0;

    // Reset clears everything; BUSYWAIT held low during reset even with READ.
    @(posedge CLK);
    #1 RESET = 1'b0;
    READ = 1'b1;
    @(negedge CLK);
    check("reset_busy_with_read", 32'(BUSYWAIT), 32'd0);
    @(negedge CLK);
    check_reset_outputs("reset2");
    READ = 1'b0;
    @(posedge CLK);
    #1 RESET = 1'b1;

    // READ and WRITE together: no access, ERROR set.
    @(posedge CLK);
    #1;
    READ = 1'b1;
    WRITE = 1'b1;
    ADDRESS = 8'h10;
    @(negedge CLK);
    check("both_busy", 32'(BUSYWAIT), 32'd0);
    @(negedge CLK);
    check("both_error", 32'(ERROR), 32'd1);
    check("both_no_read", 32'(MEM_READ), 32'd0);
    check("both_no_write", 32'(MEM_WRITE), 32'd0);
    check("both_state", 32'(DEBUG_STATE), 32'(S_IDLE));
    READ = 1'b0;
    WRITE = 1'b0;
    pulse_reset();

    // Reset on the second ACCESS cycle of a store aborts it.
    start_req(1'b0, 1'b1, 8'h30, 8'h77, 10);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    WRITE = 1'b0;
    @(negedge CLK);
    check("abort_busy_low", 32'(BUSYWAIT), 32'd0);
    check("abort_strobe_before_edge", 32'(MEM_WRITE), 32'd1);
    @(negedge CLK);
    check_reset_outputs("abort");
    check("abort_mem_0x30_untouched", 32'(mem_vld[8'h30] === 1'b1), 32'd0);
    @(posedge CLK);
    #1 RESET = 1'b1;

    expect_txn(8'hA5, 1'b0, 3, 2);
    start_req(1'b1, 1'b0, 8'h10, 8'h00, 0);
    wait_done("post_abort_load");
    READ = 1'b0;

    repeat (3) @(negedge CLK);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog expired");
  end

endmodule
